// File: rtl/mipi_sensor_cfg_seq.sv
// ---------------------------------------------------------------------------
// mipi_sensor_cfg_seq
//
// Power-up and register-configuration sequencer for a MIPI camera sensor.
// After reset it holds the sensor in reset and waits for power-up. It then
// walks a synchronous configuration table and writes each entry to the
// sensor through an external I2C master.
//
// Table entry format: {reg[15:0], val[7:0]}
//   reg = 16'hFFFF : end of table
//   reg = 16'hFFFE : wait val milliseconds (val = 0 -> no wait)
//   otherwise      : write val to sensor register reg
//
// Optional feature (compile-time macro CFG_NACK_RETRY_EN):
//   defined   - a NACKed write is re-issued up to MAX_RETRY times before the
//               sequence stops in ERROR
//   undefined - the first NACK stops the sequence in ERROR
//
// Ports:
//   clk_50m      in   single clock
//   rst_n        in   asynchronous active-low reset
//   start        in   one-cycle pulse, re-runs the sequence from DONE/ERROR
//   sensor_rst_n out  active-low sensor reset
//   tbl_addr     out  config table read address
//   tbl_data     in   table entry, valid one cycle after tbl_addr
//   i2c_req      out  write request to the I2C master
//   i2c_addr     out  sensor register address
//   i2c_wdata    out  sensor register write data
//   i2c_ack      in   one-cycle pulse, write completed with ACK
//   i2c_nack     in   one-cycle pulse, write completed with NACK
//   busy         out  sequence running (every state except DONE and ERROR)
//   done         out  sequence completed
//   err          out  sequence aborted on a NACK
//   err_index    out  table index of the failing entry
// ---------------------------------------------------------------------------
module mipi_sensor_cfg_seq #(
  parameter int CLK_PER_MS  = 50000,
  parameter int RST_HOLD_MS = 1,
  parameter int PWRUP_MS    = 20,
  parameter int TBL_AW      = 8,
  parameter int MAX_RETRY   = 3
) (
  input  logic              clk_50m,
  input  logic              rst_n,
  input  logic              start,
  output logic              sensor_rst_n,
  output logic [TBL_AW-1:0] tbl_addr,
  input  logic [23:0]       tbl_data,
  output logic              i2c_req,
  output logic [15:0]       i2c_addr,
  output logic [7:0]        i2c_wdata,
  input  logic              i2c_ack,
  input  logic              i2c_nack,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [TBL_AW-1:0] err_index
);

  // Prescaler counts clk_50m cycles within one millisecond.
  localparam int PRE_W = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_PER_MS - 1);
  localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);

  // Millisecond targets are stored as "last count" values (n-1).
  localparam logic [7:0] HOLD_MS_LAST = 8'(RST_HOLD_MS - 1);
  localparam logic [7:0] PWR_MS_LAST  = 8'(PWRUP_MS - 1);

  localparam logic [TBL_AW-1:0] ADDR_LAST = {TBL_AW{1'b1}};
  localparam logic [TBL_AW-1:0] ADDR_ONE  = TBL_AW'(1);

  localparam logic [15:0] REG_END   = 16'hFFFF;
  localparam logic [15:0] REG_DELAY = 16'hFFFE;

`ifdef CFG_NACK_RETRY_EN
  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);
  localparam logic [RETRY_W-1:0] RETRY_ONE   = RETRY_W'(1);
`endif

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    RST_HOLD  = 4'd1,
    PWR_WAIT  = 4'd2,
    FETCH     = 4'd3,
    DECODE    = 4'd4,
    WRITE     = 4'd5,
    WAIT_RESP = 4'd6,
    DELAY     = 4'd7,
    DONE      = 4'd8,
    ERROR     = 4'd9
  } state_t;

  state_t              state_r;
  logic                sensor_rst_n_r;
  logic [TBL_AW-1:0]   tbl_addr_r;
  logic                i2c_req_r;
  logic [15:0]         i2c_addr_r;
  logic [7:0]          i2c_wdata_r;
  logic                busy_r;
  logic                done_r;
  logic                err_r;
  logic [TBL_AW-1:0]   err_index_r;
  logic [PRE_W-1:0]    pre_cnt_r;
  logic [7:0]          ms_cnt_r;
  logic [7:0]          delay_ms_r;
`ifdef CFG_NACK_RETRY_EN
  logic [RETRY_W-1:0]  retry_cnt_r;
`endif

  logic [15:0] ent_reg_s;
  logic [7:0]  ent_val_s;
  logic        pre_wrap_s;
  logic [7:0]  ms_last_s;
  logic        tmr_done_s;
  logic        addr_last_s;

  assign ent_reg_s   = tbl_data[23:8];
  assign ent_val_s   = tbl_data[7:0];
  assign pre_wrap_s  = (pre_cnt_r == PRE_LAST);
  assign tmr_done_s  = pre_wrap_s && (ms_cnt_r == ms_last_s);
  assign addr_last_s = (tbl_addr_r == ADDR_LAST);

  // Select the millisecond target of whichever timed state is active.
  always_comb begin
    ms_last_s = 8'd0;
    case (state_r)
      RST_HOLD: ms_last_s = HOLD_MS_LAST;
      PWR_WAIT: ms_last_s = PWR_MS_LAST;
      DELAY:    ms_last_s = delay_ms_r - 8'd1;
      default:  ms_last_s = 8'd0;
    endcase
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      sensor_rst_n_r <= 1'b0;
      tbl_addr_r     <= '0;
      i2c_req_r      <= 1'b0;
      i2c_addr_r     <= 16'd0;
      i2c_wdata_r    <= 8'd0;
      busy_r         <= 1'b1;
      done_r         <= 1'b0;
      err_r          <= 1'b0;
      err_index_r    <= '0;
      pre_cnt_r      <= '0;
      ms_cnt_r       <= 8'd0;
      delay_ms_r     <= 8'd0;
`ifdef CFG_NACK_RETRY_EN
      retry_cnt_r    <= '0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          state_r        <= RST_HOLD;
          sensor_rst_n_r <= 1'b0;
          tbl_addr_r     <= '0;
          pre_cnt_r      <= '0;
          ms_cnt_r       <= 8'd0;
        end

        RST_HOLD: begin
          tbl_addr_r <= '0;
          if (tmr_done_s) begin
            state_r        <= PWR_WAIT;
            sensor_rst_n_r <= 1'b1;
            pre_cnt_r      <= '0;
            ms_cnt_r       <= 8'd0;
          end else if (pre_wrap_s) begin
            sensor_rst_n_r <= 1'b0;
            pre_cnt_r      <= '0;
            ms_cnt_r       <= ms_cnt_r + 8'd1;
          end else begin
            sensor_rst_n_r <= 1'b0;
            pre_cnt_r      <= pre_cnt_r + PRE_ONE;
          end
        end

        PWR_WAIT: begin
          if (tmr_done_s) begin
            state_r   <= FETCH;
            pre_cnt_r <= '0;
            ms_cnt_r  <= 8'd0;
          end else if (pre_wrap_s) begin
            pre_cnt_r <= '0;
            ms_cnt_r  <= ms_cnt_r + 8'd1;
          end else begin
            pre_cnt_r <= pre_cnt_r + PRE_ONE;
          end
        end

        // tbl_addr is already stable; the table registers it at this edge.
        FETCH: begin
          state_r <= DECODE;
        end

        DECODE: begin
`ifdef CFG_NACK_RETRY_EN
          retry_cnt_r <= '0;
`endif
          if (ent_reg_s == REG_END) begin
            state_r <= DONE;
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
          end else if (ent_reg_s == REG_DELAY) begin
            if (ent_val_s == 8'd0) begin
              // Zero-length delay completes the entry immediately.
              if (addr_last_s) begin
                state_r <= DONE;
                done_r  <= 1'b1;
                busy_r  <= 1'b0;
              end else begin
                state_r    <= FETCH;
                tbl_addr_r <= tbl_addr_r + ADDR_ONE;
              end
            end else begin
              state_r    <= DELAY;
              delay_ms_r <= ent_val_s;
              pre_cnt_r  <= '0;
              ms_cnt_r   <= 8'd0;
            end
          end else begin
            // Address/data only change here, while i2c_req is low.
            state_r     <= WRITE;
            i2c_addr_r  <= ent_reg_s;
            i2c_wdata_r <= ent_val_s;
            i2c_req_r   <= 1'b1;
          end
        end

        // WRITE is the first request cycle; after a retried NACK it is the
        // single low cycle before the request is raised again. Responses
        // only count while the request is actually up.
        WRITE, WAIT_RESP: begin
          if (i2c_req_r && i2c_nack) begin
            i2c_req_r <= 1'b0;
`ifdef CFG_NACK_RETRY_EN
            if (retry_cnt_r < RETRY_LIMIT) begin
              state_r     <= WRITE;
              retry_cnt_r <= retry_cnt_r + RETRY_ONE;
            end else
`endif
            begin
              state_r     <= ERROR;
              err_r       <= 1'b1;
              busy_r      <= 1'b0;
              err_index_r <= tbl_addr_r;
            end
          end else if (i2c_req_r && i2c_ack) begin
            i2c_req_r <= 1'b0;
            if (addr_last_s) begin
              state_r <= DONE;
              done_r  <= 1'b1;
              busy_r  <= 1'b0;
            end else begin
              state_r    <= FETCH;
              tbl_addr_r <= tbl_addr_r + ADDR_ONE;
            end
          end else begin
            state_r   <= WAIT_RESP;
            i2c_req_r <= 1'b1;
          end
        end

        DELAY: begin
          if (tmr_done_s) begin
            pre_cnt_r <= '0;
            ms_cnt_r  <= 8'd0;
            if (addr_last_s) begin
              state_r <= DONE;
              done_r  <= 1'b1;
              busy_r  <= 1'b0;
            end else begin
              state_r    <= FETCH;
              tbl_addr_r <= tbl_addr_r + ADDR_ONE;
            end
          end else if (pre_wrap_s) begin
            pre_cnt_r <= '0;
            ms_cnt_r  <= ms_cnt_r + 8'd1;
          end else begin
            pre_cnt_r <= pre_cnt_r + PRE_ONE;
          end
        end

        // Terminal states: only start leaves them, replaying from reset hold.
        DONE, ERROR: begin
          if (start) begin
            state_r        <= RST_HOLD;
            sensor_rst_n_r <= 1'b0;
            tbl_addr_r     <= '0;
            busy_r         <= 1'b1;
            done_r         <= 1'b0;
            err_r          <= 1'b0;
            err_index_r    <= '0;
            pre_cnt_r      <= '0;
            ms_cnt_r       <= 8'd0;
          end else begin
            state_r <= state_r;
          end
        end

        default: begin
          state_r        <= IDLE;
          sensor_rst_n_r <= 1'b0;
          i2c_req_r      <= 1'b0;
          busy_r         <= 1'b1;
          done_r         <= 1'b0;
          err_r          <= 1'b0;
        end
      endcase
    end
  end

  assign sensor_rst_n = sensor_rst_n_r;
  assign tbl_addr     = tbl_addr_r;
  assign i2c_req      = i2c_req_r;
  assign i2c_addr     = i2c_addr_r;
  assign i2c_wdata    = i2c_wdata_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign err          = err_r;
  assign err_index    = err_index_r;

endmodule

// File: doc/mipi_sensor_cfg_seq.md
MIPI_SENSOR_CFG_SEQ -- requirements
Module: mipi_sensor_cfg_seq

Interface
REQ-001 The module SHALL have parameter CLK_PER_MS, default 50000, giving clk_50m cycles per millisecond.
REQ-002 The module SHALL have parameter RST_HOLD_MS, default 1, giving the sensor reset hold time in ms.
REQ-003 The module SHALL have parameter PWRUP_MS, default 20, giving the wait after reset release in ms.
REQ-004 The module SHALL have parameter TBL_AW, default 8, giving the config table address width.
REQ-005 The module SHALL have parameter MAX_RETRY, default 3, giving NACK retries per entry.
REQ-006 The module SHALL have port clk_50m, input, 1 bit: the single clock.
REQ-007 The module SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-008 The module SHALL have port start, input, 1 bit: single-cycle pulse requesting a re-run.
REQ-009 The module SHALL have port sensor_rst_n, output, 1 bit: active-low sensor reset.
REQ-010 The module SHALL have port tbl_addr, output, TBL_AW bits: config table read address.
REQ-011 The module SHALL have port tbl_data, input, 24 bits: table entry {reg[15:0], val[7:0]}, valid 1 cycle after tbl_addr.
REQ-012 The module SHALL have port i2c_req, output, 1 bit: write request to the I2C master.
REQ-013 The module SHALL have port i2c_addr, output, 16 bits: sensor register address.
REQ-014 The module SHALL have port i2c_wdata, output, 8 bits: register write data.
REQ-015 The module SHALL have port i2c_ack, input, 1 bit: single-cycle pulse signalling the write completed with ACK.
REQ-016 The module SHALL have port i2c_nack, input, 1 bit: single-cycle pulse signalling the write completed with NACK.
REQ-017 The module SHALL have ports busy, done and err, outputs, 1 bit each: sequence status.
REQ-018 The module SHALL have port err_index, output, TBL_AW bits: table index of the failing entry.

Function
REQ-019 The FSM SHALL use states IDLE, RST_HOLD, PWR_WAIT, FETCH, DECODE, WRITE, WAIT_RESP, DELAY, DONE and ERROR.
REQ-020 IDLE SHALL go to RST_HOLD on the first clock after reset deassertion; RST_HOLD SHALL drive sensor_rst_n=0 and clear tbl_addr.
REQ-021 RST_HOLD SHALL last exactly RST_HOLD_MS*CLK_PER_MS cycles, then go to PWR_WAIT with sensor_rst_n=1.
REQ-022 PWR_WAIT SHALL last exactly PWRUP_MS*CLK_PER_MS cycles, then go to FETCH.
REQ-023 FETCH SHALL present tbl_addr for one cycle, then go to DECODE, which samples tbl_data.
REQ-024 DECODE SHALL go to DONE on reg=16'hFFFF (end marker).
REQ-025 DECODE SHALL go to DELAY on reg=16'hFFFE, delaying val ms; val=0 SHALL pass straight back to FETCH with the next address.
REQ-026 For any other reg value, DECODE SHALL go to WRITE, and i2c_req SHALL rise the cycle after DECODE.
REQ-027 While i2c_req=1, i2c_addr and i2c_wdata SHALL be held stable.
REQ-028 In WAIT_RESP, i2c_req SHALL stay high until i2c_ack or i2c_nack, and SHALL deassert the cycle after the response.
REQ-029 On ACK, tbl_addr SHALL increment and the FSM SHALL go to FETCH.
REQ-030 On i2c_ack and i2c_nack in the same cycle, NACK SHALL take priority.
REQ-031 If tbl_addr equals all-ones and that entry completes without an end marker, the FSM SHALL go to DONE, with no wrap-around.
REQ-032 done SHALL be 1 only in DONE, and err SHALL be 1 only in ERROR; busy SHALL be 1 in every state except DONE and ERROR (IDLE included).
REQ-033 start SHALL be ignored while busy=1; in DONE or ERROR, start SHALL clear done, err and err_index and go to RST_HOLD.
REQ-034 The delay counter SHALL use a cycle prescaler of width ceil(log2(CLK_PER_MS)) plus an 8-bit ms counter.

Reset
REQ-035 On rst_n=0, all state SHALL clear asynchronously: FSM=IDLE, sensor_rst_n=0, i2c_req=0, i2c_addr=0, i2c_wdata=0, tbl_addr=0, busy=1, done=0, err=0, err_index=0, counters=0.
REQ-036 Reset asserted mid-transaction SHALL drop i2c_req immediately, and the full sequence SHALL restart after release.

Configuration
REQ-037 With CFG_NACK_RETRY_EN defined, a NACK SHALL re-issue the same entry (i2c_req re-rises 1 cycle after the NACK) up to MAX_RETRY times, with the retry count cleared per entry.
REQ-038 With CFG_NACK_RETRY_EN defined, the (MAX_RETRY+1)th NACK SHALL enter ERROR.
REQ-039 Without CFG_NACK_RETRY_EN, the first NACK SHALL enter ERROR.
REQ-040 On entering ERROR, err_index SHALL equal tbl_addr of the failing entry.

Verification
REQ-041 Bench SHALL run CLK_PER_MS=10, table {0x3008,0x82},{0x0100,0x01},{0xFFFF,xx}, ACK 3 cycles after each req -> sensor_rst_n low 10 cycles; first req 200 cycles later; two writes in order; done=1, busy=0.
REQ-042 Bench SHALL insert {0xFFFE,0x03} between writes -> gap between 1st ACK and 2nd i2c_req rise of 30 cycles plus fixed FSM overhead; val=0x00 -> no extra gap.
REQ-043 Bench SHALL NACK entry 1 always -> with macro, 4 requests then err=1, err_index=1; without macro, 1 request then err=1.
REQ-044 Bench SHALL pulse ack and nack together on entry 0 with the macro undefined -> ERROR, err_index=0.
REQ-045 Bench SHALL pulse start while busy -> ignored; pulse start in DONE -> done=0, sensor_rst_n=0 next cycle, full replay.
REQ-046 Bench SHALL assert rst_n=0 during WAIT_RESP -> i2c_req=0 asynchronously; after release the sequence restarts from entry 0.
